// File: rtl/hazard_ctrl_if.sv
// Pipeline-control bundle between the RV32I ID stage and the hazard controller.
// The slave side is the hazard controller; the master side is the pipeline datapath.
interface hazard_ctrl_if #(
  parameter int FWD_W = 2
);
  logic [31:0]      id_inst;
  logic             id_valid;
  logic             ex_redirect;
  logic             pc_stall;
  logic             ifid_stall;
  logic             ifid_flush;
  logic             idex_flush;
  logic [FWD_W-1:0] ex_fwd_a;
  logic [FWD_W-1:0] ex_fwd_b;

  modport master (
    output id_inst, id_valid, ex_redirect,
    input  pc_stall, ifid_stall, ifid_flush, idex_flush, ex_fwd_a, ex_fwd_b
  );

  modport slave (
    input  id_inst, id_valid, ex_redirect,
    output pc_stall, ifid_stall, ifid_flush, idex_flush, ex_fwd_a, ex_fwd_b
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage RV32I core: stalls, flushes and registered forwarding selects.
// Define HAZARD_FWD_EN to enable EX operand forwarding (otherwise every RAW hazard stalls).
module hazard_ctrl #(
  parameter int FWD_W = 2
) (
  input  logic          clk,
  input  logic          rst,
  hazard_ctrl_if.slave  hz
);

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_LOAD = 7'b0000011;
  localparam logic [6:0] OP_S    = 7'b0100011;
  localparam logic [6:0] OP_B    = 7'b1100011;
  localparam logic [6:0] OP_JALR = 7'b1100111;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       we;
    logic       load;
  } slot_t;

  // The register file is write-through, so a WB producer is never observable here
  // and only the EX and MEM shadow slots are kept.
  slot_t r_ex;
  slot_t r_mem;

  logic [6:0] w_opcode;
  logic [4:0] w_rd;
  logic [4:0] w_rs1;
  logic [4:0] w_rs2;
  logic       w_uses_rs1;
  logic       w_uses_rs2;
  logic       w_writes_rd;
  logic       w_is_load;
  logic       w_ex_hit_a;
  logic       w_ex_hit_b;
  logic       w_mem_hit_a;
  logic       w_mem_hit_b;
  logic       w_hazard;
  logic       w_issue;
  logic       w_unused;

  function automatic logic slot_match(slot_t s, logic [4:0] rs);
    return s.valid && s.we && (s.rd == rs) && (rs != 5'd0);
  endfunction

  assign w_opcode    = hz.id_inst[6:0];
  assign w_rd        = hz.id_inst[11:7];
  assign w_rs1       = hz.id_inst[19:15];
  assign w_rs2       = hz.id_inst[24:20];
  assign w_uses_rs1  = hz.id_valid && (w_opcode inside {OP_R, OP_I, OP_LOAD, OP_S, OP_B, OP_JALR});
  assign w_uses_rs2  = hz.id_valid && (w_opcode inside {OP_R, OP_S, OP_B});
  assign w_writes_rd = hz.id_valid && !(w_opcode inside {OP_S, OP_B}) && (w_rd != 5'd0);
  assign w_is_load   = hz.id_valid && (w_opcode == OP_LOAD);

  assign w_ex_hit_a  = w_uses_rs1 && slot_match(r_ex,  w_rs1);
  assign w_ex_hit_b  = w_uses_rs2 && slot_match(r_ex,  w_rs2);
  assign w_mem_hit_a = w_uses_rs1 && slot_match(r_mem, w_rs1);
  assign w_mem_hit_b = w_uses_rs2 && slot_match(r_mem, w_rs2);

`ifdef HAZARD_FWD_EN
  // Only a load in EX cannot be forwarded in time; one bubble moves it to MEM/WB.
  assign w_hazard = (w_ex_hit_a || w_ex_hit_b) && r_ex.load;
`else
  assign w_hazard = w_ex_hit_a || w_ex_hit_b || w_mem_hit_a || w_mem_hit_b;
`endif

  // A redirect kills the ID instruction, so it overrides any pending stall.
  assign hz.pc_stall   = !rst && w_hazard && !hz.ex_redirect;
  assign hz.ifid_stall = !rst && w_hazard && !hz.ex_redirect;
  assign hz.ifid_flush = !rst && hz.ex_redirect;
  assign hz.idex_flush = !rst && (w_hazard || hz.ex_redirect);

  assign w_issue = hz.id_valid && !w_hazard && !hz.ex_redirect;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ex  <= '0;
      r_mem <= '0;
    end else begin
      r_mem <= r_ex;
      if (w_issue) begin
        r_ex <= '{valid: 1'b1, rd: w_rd, we: w_writes_rd, load: w_is_load};
      end else begin
        r_ex <= '0;
      end
    end
  end

`ifdef HAZARD_FWD_EN
  logic [FWD_W-1:0] r_fwd_a;
  logic [FWD_W-1:0] r_fwd_b;

  function automatic logic [FWD_W-1:0] fwd_sel(logic ex_hit, logic mem_hit);
    if (ex_hit) begin
      return FWD_W'(1);
    end else if (mem_hit) begin
      return FWD_W'(2);
    end
    return '0;
  endfunction

  // Selects are latched on the edge the consumer enters EX and held for its EX cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fwd_a <= '0;
      r_fwd_b <= '0;
    end else if (w_issue) begin
      r_fwd_a <= fwd_sel(w_ex_hit_a, w_mem_hit_a);
      r_fwd_b <= fwd_sel(w_ex_hit_b, w_mem_hit_b);
    end else begin
      r_fwd_a <= '0;
      r_fwd_b <= '0;
    end
  end

  assign hz.ex_fwd_a = r_fwd_a;
  assign hz.ex_fwd_b = r_fwd_b;
`else
  assign hz.ex_fwd_a = '0;
  assign hz.ex_fwd_b = '0;
`endif

  assign w_unused = ^{hz.id_inst[31:25], hz.id_inst[14:12], r_ex.load, r_mem.load};

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed test-plan sequences followed by random
// instruction streams, all checked against a dependency-distance reference model.
module tb_hazard_ctrl;

  logic clk;
  logic rst;
  int   compareCount;
  int   mismatchCount;

  hazard_ctrl_if #(.FWD_W(2)) hzIf ();

  hazard_ctrl #(.FWD_W(2)) dut (
    .clk (clk),
    .rst (rst),
    .hz  (hzIf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: what entered EX one edge ago (dist1) and two edges ago (dist2).
  typedef struct {
    bit       v;
    bit [4:0] rd;
    bit       we;
    bit       ld;
  } prodT;

  prodT     dist1;
  prodT     dist2;
  bit [1:0] expFwdA;
  bit [1:0] expFwdB;
  bit       lastHold;

  function automatic bit usesRs1(bit [6:0] op);
    return op == 7'b0110011 || op == 7'b0010011 || op == 7'b0000011 ||
           op == 7'b0100011 || op == 7'b1100011 || op == 7'b1100111;
  endfunction

  function automatic bit usesRs2(bit [6:0] op);
    return op == 7'b0110011 || op == 7'b0100011 || op == 7'b1100011;
  endfunction

  function automatic bit hits(prodT p, bit [4:0] r);
    return p.v && p.we && p.rd == r && r != 0;
  endfunction

  function automatic logic [31:0] mkR(bit [4:0] rd, bit [4:0] rs1, bit [4:0] rs2);
    return {7'b0, rs2, rs1, 3'b000, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] mkLw(bit [4:0] rd, bit [4:0] rs1);
    return {12'b0, rs1, 3'b010, rd, 7'b0000011};
  endfunction

  function automatic logic [31:0] mkSw(bit [4:0] rs2, bit [4:0] rs1);
    return {7'b0, rs2, rs1, 3'b010, 5'b0, 7'b0100011};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    compareCount++;
    if (actual !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s at %0t: got %0h expected %0h", tag, $time, actual, expected);
    end
  endtask

  // One clock cycle: drive at negedge, check mid-low-phase, advance the model on posedge.
  task automatic applyStimulus(input logic [31:0] inst, input bit valid, input bit redir, input bit rstIn);
    bit [6:0] op;
    bit [4:0] rd, rs1, rs2;
    bit u1, u2, h1a, h1b, h2a, h2b, stall, issue;
    bit [1:0] nextA, nextB;
    @(negedge clk);
    rst              = rstIn;
    hzIf.id_inst     = inst;
    hzIf.id_valid    = valid;
    hzIf.ex_redirect = redir;
    op  = inst[6:0];
    rd  = inst[11:7];
    rs1 = inst[19:15];
    rs2 = inst[24:20];
    u1  = valid && usesRs1(op);
    u2  = valid && usesRs2(op);
    h1a = u1 && hits(dist1, rs1);
    h1b = u2 && hits(dist1, rs2);
    h2a = u1 && hits(dist2, rs1);
    h2b = u2 && hits(dist2, rs2);
`ifdef HAZARD_FWD_EN
    stall = (h1a || h1b) && dist1.ld;
`else
    stall = h1a || h1b || h2a || h2b;
`endif
    #2;
    checkOutput("pc_stall",   {31'b0, hzIf.pc_stall},   {31'b0, !rstIn && stall && !redir});
    checkOutput("ifid_stall", {31'b0, hzIf.ifid_stall}, {31'b0, !rstIn && stall && !redir});
    checkOutput("ifid_flush", {31'b0, hzIf.ifid_flush}, {31'b0, !rstIn && redir});
    checkOutput("idex_flush", {31'b0, hzIf.idex_flush}, {31'b0, !rstIn && (stall || redir)});
    checkOutput("ex_fwd_a",   {30'b0, hzIf.ex_fwd_a},   {30'b0, expFwdA});
    checkOutput("ex_fwd_b",   {30'b0, hzIf.ex_fwd_b},   {30'b0, expFwdB});
    @(posedge clk);
    issue = !rstIn && valid && !stall && !redir;
    nextA = 2'd0;
    nextB = 2'd0;
`ifdef HAZARD_FWD_EN
    if (issue) begin
      nextA = h1a ? 2'd1 : (h2a ? 2'd2 : 2'd0);
      nextB = h1b ? 2'd1 : (h2b ? 2'd2 : 2'd0);
    end
`endif
    expFwdA = nextA;
    expFwdB = nextB;
    if (rstIn) begin
      dist1 = '{default: 0};
      dist2 = '{default: 0};
    end else begin
      dist2 = dist1;
      if (issue) begin
        dist1.v  = 1;
        dist1.rd = rd;
        dist1.we = op != 7'b0100011 && op != 7'b1100011 && rd != 0;
        dist1.ld = op == 7'b0000011;
      end else begin
        dist1 = '{default: 0};
      end
    end
    lastHold = !rstIn && valid && stall && !redir;
  endtask

  function automatic logic [31:0] randInst();
    logic [6:0] ops [9];
    logic [31:0] w;
    ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
            7'b1100111, 7'b1101111, 7'b0110111, 7'b0010111};
    w = $urandom;
    w[6:0]   = ops[$urandom_range(0, 8)];
    w[11:7]  = 5'($urandom_range(0, 3));
    w[19:15] = 5'($urandom_range(0, 3));
    w[24:20] = 5'($urandom_range(0, 3));
    return w;
  endfunction

  initial begin
    logic [31:0] inst;
    bit valid;
    compareCount     = 0;
    mismatchCount    = 0;
    dist1            = '{default: 0};
    dist2            = '{default: 0};
    expFwdA          = 0;
    expFwdB          = 0;
    lastHold         = 0;
    rst              = 1'b1;
    hzIf.id_inst     = 32'h0;
    hzIf.id_valid    = 1'b0;
    hzIf.ex_redirect = 1'b0;
    repeat (2) @(posedge clk);

    applyStimulus(mkR(5'd1, 5'd1, 5'd1), 1, 0, 1);

    // Forwarding pair: add x1,x2,x3 ; add x4,x1,x1
    applyStimulus(mkR(5'd1, 5'd2, 5'd3), 1, 0, 0);
    applyStimulus(mkR(5'd4, 5'd1, 5'd1), 1, 0, 0);
    applyStimulus(mkR(5'd4, 5'd1, 5'd1), lastHold, 0, 0);
    applyStimulus(mkR(5'd4, 5'd1, 5'd1), lastHold, 0, 0);
    applyStimulus(32'h0, 0, 0, 0);
    applyStimulus(32'h0, 0, 0, 0);

    // Load-use followed by two consumers
    applyStimulus(mkLw(5'd5, 5'd0), 1, 0, 0);
    applyStimulus(mkR(5'd6, 5'd5, 5'd0), 1, 0, 0);
    applyStimulus(mkR(5'd6, 5'd5, 5'd0), 1, 0, 0);
    applyStimulus(mkR(5'd7, 5'd5, 5'd5), 1, 0, 0);
    applyStimulus(32'h0, 0, 0, 0);
    applyStimulus(32'h0, 0, 0, 0);

    // Redirect in the stall cycle
    applyStimulus(mkLw(5'd5, 5'd0), 1, 0, 0);
    applyStimulus(mkR(5'd6, 5'd5, 5'd0), 1, 1, 0);
    applyStimulus(mkR(5'd8, 5'd9, 5'd10), 1, 0, 0);
    applyStimulus(32'h0, 0, 0, 0);
    applyStimulus(32'h0, 0, 0, 0);

    // x0 producer and store producer
    applyStimulus(mkR(5'd0, 5'd1, 5'd2), 1, 0, 0);
    applyStimulus(mkR(5'd7, 5'd0, 5'd0), 1, 0, 0);
    applyStimulus(mkSw(5'd1, 5'd2), 1, 0, 0);
    applyStimulus(mkR(5'd3, 5'd1, 5'd1), 1, 0, 0);
    applyStimulus(32'h0, 0, 0, 0);
    applyStimulus(32'h0, 0, 0, 0);

    // Reset asserted during a load-use stall
    applyStimulus(mkLw(5'd5, 5'd0), 1, 0, 0);
    applyStimulus(mkR(5'd6, 5'd5, 5'd0), 1, 0, 0);
    applyStimulus(mkR(5'd6, 5'd5, 5'd0), 1, 0, 1);
    applyStimulus(mkR(5'd6, 5'd5, 5'd0), 1, 0, 0);
    applyStimulus(32'h0, 0, 0, 0);

    // Random instruction stream; a stalled ID instruction is held as the pipeline would
    inst = randInst();
    for (int i = 0; i < 600; i++) begin
      if (!lastHold) begin
        inst  = randInst();
        valid = ($urandom_range(0, 9) != 0);
      end else begin
        valid = 1;
      end
      applyStimulus(inst, valid, ($urandom_range(0, 11) == 0), ($urandom_range(0, 49) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
